// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module  : matrix_pkg
// Brief   : Shared geometry, scan-state and owner encodings for the 4x4
//           LED matrix scan arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int FRAME_W = ROWS * COLS;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    typedef enum logic [0:0] {
        OWN_P1 = 1'b0,
        OWN_P2 = 1'b1
    } owner_t;

    // Bit 4*r+c of a frame is row r, column c.
    function automatic logic [COLS-1:0] row_nibble(
        input logic [FRAME_W-1:0] frame,
        input logic [ROW_W-1:0]   row
    );
        return frame[row * COLS +: COLS];
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : matrix_rr_arbiter
// Brief   : Two-way round-robin arbiter; the priority flop moves to the other
//           requester after every grant, even an uncontested one.
// Revision: 1.0 - initial release
// ============================================================================
module matrix_rr_arbiter
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    owner_t r_prio;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req[0] && (!req[1] || (r_prio == OWN_P1))) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    // A grant is always taken since the requester is already valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= OWN_P1;
        end else if (gnt[0]) begin
            r_prio <= OWN_P2;
        end else if (gnt[1]) begin
            r_prio <= OWN_P1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : matrix_scan_arbiter
// Brief   : Row-multiplexed 4x4 LED scan with blanking, fed by two requesters
//           through a round-robin arbiter and a tear-free back/front buffer.
// Revision: 1.0 - initial release
// ============================================================================
module matrix_scan_arbiter
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FRAME_W-1:0]  p1_frame,
    input  logic                p1_valid,
    output logic                p1_ready,
    input  logic [FRAME_W-1:0]  p2_frame,
    input  logic                p2_valid,
    output logic                p2_ready,
    output logic [ROWS-1:0]     row_en,
    output logic [COLS-1:0]     col_data,
    output logic                frame_sync,
    output logic                owner
);

    localparam int                 c_cnt_w    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0]   c_row_last = ROW_W'(ROWS - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [ROW_W-1:0]     r_row;
    logic [ROW_W-1:0]     w_row_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_leave_on;
    logic                 w_swap;

    logic [FRAME_W-1:0]   r_front;
    logic [FRAME_W-1:0]   r_back;
    owner_t               r_owner;
    owner_t               r_back_owner;
    logic                 r_pending;

    logic [1:0]           w_gnt;
    logic                 w_arb_en;

    assign w_arb_en = !r_pending;

    matrix_rr_arbiter u_arbiter (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({p2_valid, p1_valid}),
        .enable (w_arb_en),
        .gnt    (w_gnt)
    );

    assign p1_ready = w_gnt[0];
    assign p2_ready = w_gnt[1];
    assign owner    = r_owner;

    // Scan next-state and row/column drive
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        w_leave_on  = 1'b0;
        row_en      = '0;
        col_data    = '0;
        frame_sync  = 1'b0;

        case (r_state)
            BLANK: begin
                w_state_nxt = ON;
            end
            ON: begin
                row_en[r_row] = 1'b1;
                col_data      = row_nibble(r_front, r_row);
                frame_sync    = (r_row == '0) && (r_cnt == '0);
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                    w_row_nxt   = r_row + ROW_W'(1);
                    w_leave_on  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BLANK;
            r_row   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Swap only at the end of the last row so a frame is never torn.
    assign w_swap = w_leave_on && (r_row == c_row_last) && r_pending;

    // Grants are masked while pending, so accept and swap never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front      <= '0;
            r_back       <= '0;
            r_owner      <= OWN_P1;
            r_back_owner <= OWN_P1;
            r_pending    <= 1'b0;
        end else if (w_swap) begin
            r_front      <= r_back;
            r_owner      <= r_back_owner;
            r_pending    <= 1'b0;
        end else if (w_gnt[0]) begin
            r_back       <= p1_frame;
            r_back_owner <= OWN_P1;
            r_pending    <= 1'b1;
        end else if (w_gnt[1]) begin
            r_back       <= p2_frame;
            r_back_owner <= OWN_P2;
            r_pending    <= 1'b1;
        end
    end

endmodule
`default_nettype wire
